// File: rtl/tt_um_hoene_frame_tx.sv
// Smart-LED chain frame transmitter: serialises 30-bit LED words into 32-bit chain words.
// Optional FRAME_TX_PARITY_ERR_EN adds inject_err to corrupt the parity bit of a word.
module tt_um_hoene_frame_tx #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] word_data,
    input  logic        word_last,
    input  logic        word_valid,
`ifdef FRAME_TX_PARITY_ERR_EN
    input  logic        inject_err,
`endif
    output logic        word_ready,
    output logic        tx_frame,
    output logic        tx_clk,
    output logic        tx_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_STALL,
        S_TRAIL,
        S_GAP
    } state_t;

    localparam logic [8:0] BIT_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] HALF       = 9'(CLK_DIV);
    localparam logic [8:0] TRAIL_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST   = 9'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [31:0] shreg_q, shreg_d;
    logic        last_q, last_d;

    logic        frame_d, clk_d, data_d, busy_d;
    logic        xfer;
    logic        inj;
    logic [29:0] data_rev;
    logic [30:0] payload;
    logic [31:0] load_word;

`ifdef FRAME_TX_PARITY_ERR_EN
    assign inj = inject_err;
`else
    assign inj = 1'b0;
`endif

    // Chain bit k (k=1..30) carries word_data[30-k], so the payload is the bit-reversed word.
    assign data_rev  = {<<{word_data}};
    assign payload   = {data_rev, 1'b1};
    assign load_word = {(^payload) ^ inj, payload};

    assign word_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_STALL) ||
                                  ((state_q == S_SHIFT) && (bit_q == 5'd31) && (cnt_q == BIT_LAST)));
    assign xfer = word_valid && word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        case (state_q)
            S_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd31) begin
                        state_d = last_q ? S_TRAIL : S_STALL;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shreg_d = {1'b0, shreg_q[31:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_TRAIL: begin
                if (cnt_q == TRAIL_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: ;
        endcase
        // word_ready is only high in IDLE, STALL or the last cycle of bit 31,
        // so a transfer always overrides the per-state decision with a fresh load.
        if (xfer) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            bit_d   = '0;
            shreg_d = load_word;
            last_d  = word_last;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        frame_d = (state_d == S_SHIFT) || (state_d == S_STALL) || (state_d == S_TRAIL);
        clk_d   = (state_d == S_SHIFT) && (cnt_d >= HALF);
        data_d  = (state_d == S_SHIFT) && shreg_d[0];
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_frame <= 1'b0;
            tx_clk   <= 1'b0;
            tx_data  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tx_frame <= frame_d;
            tx_clk   <= clk_d;
            tx_data  <= data_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_tt_um_hoene_frame_tx.sv
// Bench for tt_um_hoene_frame_tx: scoreboard of expected serial bits plus frame timing checks.
module tb_tt_um_hoene_frame_tx;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [29:0] word_data = '0;
    logic        word_last = 1'b0;
    logic        word_valid = 1'b0;
    logic        word_ready, tx_frame, tx_clk, tx_data, busy;
`ifdef FRAME_TX_PARITY_ERR_EN
    logic        inject_err = 1'b0;
    logic        b_inject = 1'b0;
`endif

    logic [29:0] b_data = '0;
    logic        b_last = 1'b0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_frame, b_clk, b_dat, b_busy;

    tt_um_hoene_frame_tx #(.CLK_DIV(2), .GAP_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .word_data(word_data), .word_last(word_last),
        .word_valid(word_valid),
`ifdef FRAME_TX_PARITY_ERR_EN
        .inject_err(inject_err),
`endif
        .word_ready(word_ready), .tx_frame(tx_frame), .tx_clk(tx_clk),
        .tx_data(tx_data), .busy(busy)
    );

    tt_um_hoene_frame_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .word_data(b_data), .word_last(b_last),
        .word_valid(b_valid),
`ifdef FRAME_TX_PARITY_ERR_EN
        .inject_err(b_inject),
`endif
        .word_ready(b_ready), .tx_frame(b_frame), .tx_clk(b_clk),
        .tx_data(b_dat), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one expected bit per rising tx_clk.
    bit          exp_q[$];
    logic        prev_clk = 1'b0, prev_data = 1'b0, prev_frame = 1'b0;
    int          hi_run = 0, pulses = 0, falls = 0;
    logic [31:0] rx_word = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_clk = 1'b0; prev_data = 1'b0; prev_frame = 1'b0; hi_run = 0;
        end else begin
            if (tx_clk && !prev_clk) begin
                pulses++;
                rx_word = {tx_data, rx_word[31:1]};
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_underflow actual=bit %0b required=no bit", tx_data);
                end else begin
                    check("sb_bit", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            if (tx_clk && prev_clk) check("data_stable_hi", 32'(tx_data), 32'(prev_data));
            if (!tx_clk && prev_clk) check("clk_hi_width", hi_run, D);
            if (prev_frame && !tx_frame) falls++;
            hi_run = tx_clk ? hi_run + 1 : 0;
            prev_clk = tx_clk; prev_data = tx_data; prev_frame = tx_frame;
        end
    end

    int acc_cyc = 0;

    task automatic send(input logic [29:0] d, input logic l, input logic p);
        int n = 0;
        @(negedge clk);
        word_data = d; word_last = l; word_valid = 1'b1;
        exp_q.push_back(1'b1);
        for (int k = 29; k >= 0; k--) exp_q.push_back(d[k]);
        exp_q.push_back(p);
        while (!word_ready && n < 5000) begin @(negedge clk); n++; end
        check("accept_in_time", 32'(n < 5000), 1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        word_valid = 1'b0; word_last = 1'b0; word_data = 30'($urandom);
    endtask

    task automatic measure(output int hi, output int lo, output logic first_data);
        hi = 0; lo = 0;
        @(negedge clk);
        first_data = tx_data;
        while (tx_frame && hi < 5000) begin hi++; @(negedge clk); end
        while (!word_ready && lo < 5000) begin
            check("gap_frame_low", 32'(tx_frame), 0);
            lo++; @(negedge clk);
        end
    endtask

    typedef struct {
        logic [29:0] data;
        logic        par;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo, t1, f0;
        logic fd;
        logic [31:0] w;

        vecs[0] = '{30'h0000_0001, 1'b0, 32'h4000_0001};
        vecs[1] = '{30'h3FFF_FFFF, 1'b1, 32'hFFFF_FFFF};
        vecs[2] = '{30'h0000_0000, 1'b1, 32'h8000_0001};
        vecs[3] = '{30'h2AAA_AAAA, 1'b0, 32'h2AAA_AAAB};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", {27'd0, tx_frame, tx_clk, tx_data, busy, word_ready}, 0);
        check("reset_fast_ready", 32'(b_ready), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {30'd0, word_ready, busy}, 32'b10);

        // Single-word frames from the table
        foreach (vecs[i]) begin
            pulses = 0;
            send(vecs[i].data, 1'b1, vecs[i].par);
            measure(hi, lo, fd);
            check("frame_high_cycles", hi, 130);
            check("gap_cycles", lo, 8);
            check("marker_first", 32'(fd), 1);
            check("pulse_count", pulses, 32);
            check("rx_word", rx_word, vecs[i].word);
        end

        // Back-to-back words form one continuous frame
        pulses = 0; f0 = falls;
        send(30'h3FFF_FFFF, 1'b0, 1'b1);
        t1 = acc_cyc;
        send(30'h0000_0000, 1'b1, 1'b1);
        check("b2b_spacing", acc_cyc - t1, 64 * D);
        measure(hi, lo, fd);
        check("b2b_tail_high", hi, 130);
        check("b2b_single_frame", falls - f0, 1);
        check("b2b_pulses", pulses, 64);

        // Underrun: frame held open with idle serial lines
        pulses = 0; f0 = falls;
        send(30'h2AAA_AAAA, 1'b0, 1'b0);
        repeat (64 * D) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_outs", {27'd0, tx_frame, tx_clk, tx_data, word_ready, busy}, 32'b10011);
        end
        send(30'h3FFF_FFFF, 1'b1, 1'b1);
        measure(hi, lo, fd);
        check("resume_high", hi, 130);
        check("resume_marker", 32'(fd), 1);
        check("underrun_pulses", pulses, 64);
        check("underrun_one_frame", falls - f0, 1);

        // Asynchronous reset during bit 15
        send(30'h2AAA_AAAA, 1'b1, 1'b0);
        repeat (1 + 2 * 15 * D) @(negedge clk);
        check("pre_reset_outs", {29'd0, tx_frame, tx_data, busy}, 32'b111);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outs", {27'd0, tx_frame, tx_clk, tx_data, busy, word_ready}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {30'd0, word_ready, busy}, 32'b10);
        pulses = 0;
        send(30'h0000_0001, 1'b1, 1'b0);
        measure(hi, lo, fd);
        check("post_reset_high", hi, 130);
        check("post_reset_marker", 32'(fd), 1);
        check("post_reset_word", rx_word, 32'h4000_0001);

        // CLK_DIV=1, GAP_CYCLES=1 instance
        @(negedge clk);
        b_data = 30'h2AAA_AAAA; b_last = 1'b1; b_valid = 1'b1;
        check("fast_ready_idle", 32'(b_ready), 1);
        @(posedge clk); #1;
        b_valid = 1'b0; b_data = 30'($urandom); b_last = 1'b0;
        w = 32'h2AAA_AAAB;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check("fast_bit_lo", {29'd0, b_frame, b_clk, b_dat}, {29'd0, 2'b10, w[k]});
            @(negedge clk);
            check("fast_bit_hi", {29'd0, b_frame, b_clk, b_dat}, {29'd0, 2'b11, w[k]});
        end
        @(negedge clk);
        check("fast_trail", {28'd0, b_frame, b_clk, b_dat, b_ready}, 32'b1000);
        @(negedge clk);
        check("fast_gap", {30'd0, b_frame, b_ready}, 0);
        @(negedge clk);
        check("fast_ready_after_gap", 32'(b_ready), 1);
        b_data = 30'h0000_0001; b_last = 1'b1; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(negedge clk);
        check("fast_restart", {30'd0, b_frame, b_dat}, 32'b11);
        for (int n = 0; n < 500 && b_busy; n++) @(negedge clk);
        check("fast_drained", 32'(b_busy), 0);

`ifdef FRAME_TX_PARITY_ERR_EN
        inject_err = 1'b1;
        send(30'h0000_0001, 1'b1, 1'b1);
        inject_err = 1'b0;
        measure(hi, lo, fd);
        check("inject_word", rx_word, 32'hC000_0001);
        check("rx_parity_error", 32'(^rx_word), 1);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tt_um_hoene_frame_tx.md
# tt_um_hoene_frame_tx

Frame transmitter for the smart-LED daisy chain: the controller-side counterpart of the per-LED protocol receiver. It serialises 30-bit LED words into 32-bit chain words (claim marker, data, parity) and drives the frame, serial clock and serial data lines that feed the first LED's DIN. It sits in the controller/test harness, between a word source with valid/ready handshake and the chain input pins.

## Interface
- `CLK_DIV`, 2: clk cycles per half serial-clock period; legal range 1..255.
- `GAP_CYCLES`, 8: clk cycles `tx_frame` stays low after a frame before the next frame may start; legal range 1..255.

- `clk`  in  1  global clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `word_data`  in  30  LED payload; bit 29 is sent first.
- `word_last`  in  1  marks the final word of the frame; sampled with `word_data`.
- `word_valid`  in  1  source has a word.
- `word_ready`  out  1  transmitter accepts the word this cycle.
- `tx_frame`  out  1  frame envelope; low resets the receivers.
- `tx_clk`  out  1  serial clock; receivers sample while high.
- `tx_data`  out  1  serial data.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Chain word, sent bit 0 first: bit 0 = 1 (unclaimed marker); bits 1..30 = `word_data[29:0]`, MSB first; bit 31 = XOR of bits 0..30, giving even parity over 32 bits.
- Handshake: a transfer occurs when `word_valid && word_ready`. The word and `word_last` are latched into a 32-bit shift register plus a last flag. `word_data` may change freely afterwards.
- States:
  - IDLE: `word_ready`=1. A transfer moves to SHIFT and sets `tx_frame`.
  - SHIFT: 32 bits, each 2·`CLK_DIV` cycles long. In the final cycle of bit 31, `word_ready`=1:
    - transfer → next word starts seamlessly (SHIFT);
    - else if the last flag is set → TRAIL;
    - else → STALL.
  - STALL (underrun mid-frame): `tx_frame`=1, `tx_clk`=0, `tx_data`=0, `word_ready`=1. A transfer → SHIFT. Frame is never closed by underrun.
  - TRAIL: `CLK_DIV` cycles with `tx_frame`=1, `tx_clk`=0, `tx_data`=0, then → GAP.
  - GAP: `tx_frame`=0, `word_ready`=0 for `GAP_CYCLES` cycles, then → IDLE.
- `word_last` on a word accepted from STALL or SHIFT is honoured identically.
- Reset (asynchronous, any state, including mid-word): `tx_frame`=0, `tx_clk`=0, `tx_data`=0, `busy`=0, state IDLE, counters and shift register cleared. `word_ready` is forced 0 while `rst_n` is low and becomes 1 in the first cycle after release.
- All outputs are registered except `word_ready`, which is decoded from state and counters.

## Timing
- Word accepted at edge T:
  - `tx_frame`=1 and `tx_data`=bit 0 from cycle T+1.
  - Bit k is on `tx_data` for cycles T+1+2k·D .. T+(2k+2)·D, where D=`CLK_DIV`.
  - `tx_clk` is low for the first D cycles of each bit and high for the last D. Data never changes while `tx_clk` is high.
- `word_ready` high in cycle T+64·D (last cycle of bit 31). Back-to-back words therefore form a continuous stream of 64·D cycles per word.
- Last word: `tx_frame` falls at T+64·D+D+1. Earliest next accept is at GAP_CYCLES cycles after that.
- Throughput: one word per 64·`CLK_DIV` cycles.

## Configuration
- `FRAME_TX_PARITY_ERR_EN`:
  - Defined: adds input `inject_err` (1 bit), sampled on transfer. When 1, bit 31 of that word is inverted so the receiver flags a parity error. Used for error-path verification.
  - Undefined: the port does not exist and parity is always correct.

## Test plan
- Reset, CLK_DIV=2, single word 30'h0000_0001 with last=1 → `tx_data` per bit: 1, 29×0, 1, 0 (parity 0); `tx_clk` 32 pulses, each 2 cycles high; `tx_frame` high 130 cycles (T+1..T+130), then low for 8 cycles; `word_ready` 0 during those 8.
- Two back-to-back words 30'h3FFF_FFFF (last=0) then 30'h0 (last=1), `word_valid` held → no gap between words; serial 1, 30×1, 1, then 1, 30×0, 1; 64 `tx_clk` pulses in one frame.
- Underrun: first word last=0, `word_valid` dropped for 20 cycles → `tx_frame` stays 1, `tx_clk`/`tx_data` stay 0; word resumes one cycle after the transfer.
- `rst_n` pulsed low in the middle of bit 15 → all outputs 0 asynchronously; after release, `word_ready`=1 and a new frame starts with marker bit 1.
- CLK_DIV=1, GAP_CYCLES=1 → bit period of 2 cycles, `tx_clk` toggles every cycle; next frame is accepted 1 cycle after `tx_frame` falls.
- With `FRAME_TX_PARITY_ERR_EN` defined, word 30'h0000_0001 with `inject_err`=1 → bit 31 = 1; receiver model flags error and does not set PWM.
